cmp_result_monitor: RTL and testbench
=====================================

// Module: cmp_result_monitor
// PURPOSE
//  Downstream stage of the 2-bit comparator. Samples the 1-bit compare flag
//  (cmp_z) on a valid strobe and keeps statistics on it: a saturating hit
//  counter, a saturating sample counter, the current run of consecutive hits
//  and a shift-register history. A sticky alarm is raised once the run of
//  consecutive hits reaches RUN_THRESH. Results feed the status/display logic.
// PARAMETERS
//  CNT_W       8   width of hit_count, sample_count, run_len (saturating)
//  RUN_THRESH  3   consecutive cmp_z=1 samples that raise alarm (1..2^CNT_W-1)
//  HIST_DEPTH  8   number of most recent cmp_z samples held in history (>=2)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           synchronous, active-high reset
//  in_valid      in   1           cmp_z is valid this cycle; sample accepted
//  cmp_z         in   1           compare flag from the comparator stage
//  clear         in   1           synchronous soft clear of all statistics
//  out_valid     out  1           1-cycle pulse: outputs updated by a sample
//  hit_count     out  CNT_W       number of accepted samples with cmp_z=1
//  sample_count  out  CNT_W       number of accepted samples
//  run_len       out  CNT_W       current consecutive cmp_z=1 run length
//  history       out  HIST_DEPTH  bit0 = newest sample, bit HIST_DEPTH-1 oldest
//  alarm         out  1           sticky; 1 while state == ALARM
//  state         out  2           IDLE=2'd0, TRACK=2'd1, ALARM=2'd2
// BEHAVIOUR
//  - All outputs registered. Reset (rst=1 at clk edge): every output 0,
//    state=IDLE. rst has priority over clear, clear over in_valid.
//  - clear=1: same result as rst; a sample presented that cycle is dropped
//    (out_valid stays 0 next cycle).
//  - Accepted sample (in_valid=1, no rst/clear): visible on outputs the next
//    cycle together with out_valid=1 (latency 1). in_valid=0: all outputs hold,
//    out_valid=0. Back-to-back samples every cycle are supported.
//  - history <= {history[HIST_DEPTH-2:0], cmp_z}; oldest bit discarded.
//  - sample_count += 1; hit_count += cmp_z; both saturate at 2^CNT_W-1,
//    never wrap.
//  - run_len: cmp_z=1 -> run_len+1 saturating at 2^CNT_W-1; cmp_z=0 -> 0.
//  - FSM (advances only on accepted samples; clear/rst -> IDLE):
//      IDLE  -> TRACK on first accepted sample, or -> ALARM if that sample
//               makes new run_len >= RUN_THRESH (RUN_THRESH=1, cmp_z=1).
//      TRACK -> ALARM when new run_len >= RUN_THRESH; else stay TRACK.
//      ALARM -> ALARM (sticky) regardless of cmp_z; exits only on clear/rst.
//    Counters, run_len and history keep updating in ALARM.
//  - alarm == (state == ALARM), asserted in the same cycle as the out_valid
//    pulse of the triggering sample.
//  - Illegal state encoding 2'd3 -> IDLE on next edge, counters untouched.
// TESTING
//  1 rst held 2 cycles -> all outputs 0, state=0, out_valid=0.
//  2 samples z=1,0,1,1,1 (valid every cycle) -> after 5th: sample_count=5,
//    hit_count=4, run_len=3, history[4:0]=5'b10111, alarm=1 on 5th out_valid.
//  3 alarm set, then z=0 x4 -> alarm stays 1, run_len=0, state=2; pulse clear
//    -> all 0, state=0; clear with in_valid=1 same cycle -> sample dropped.
//  4 CNT_W=3: 9 samples z=1 -> hit_count=sample_count=run_len=7 (saturated),
//    no wrap to 0.
//  5 gaps: z=1,(in_valid=0 x3),z=1,z=1 -> run_len=3, alarm=1; outputs hold
//    and out_valid=0 during gap cycles.
//  6 rst mid-run (run_len=2, TRACK) -> next cycle all 0, IDLE; next z=1
//    sample -> run_len=1, state=TRACK.

Source files
------------

// File: rtl/cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// cmp_result_monitor
// Downstream stage of the 2-bit comparator. Every accepted sample of the
// compare flag updates a set of statistics:
//   - a saturating hit counter
//   - a saturating sample counter
//   - the length of the current run of consecutive hits
//   - a shift-register history of recent samples
// A sticky alarm is raised once the run of consecutive hits reaches
// RUN_THRESH. The alarm only goes away on reset or a soft clear.
//
// Parameters:
//   CNT_W       width of hit_count, sample_count and run_len (saturating)
//   RUN_THRESH  consecutive cmp_z=1 samples that raise the alarm
//   HIST_DEPTH  number of recent samples kept in history (>= 2)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid      cmp_z is valid this cycle and the sample is accepted
//   cmp_z         compare flag from the comparator stage
//   clear         synchronous soft clear of all statistics
//   out_valid     one-cycle pulse, outputs were updated by a sample
//   hit_count     accepted samples with cmp_z=1
//   sample_count  accepted samples
//   run_len       current run of consecutive cmp_z=1 samples
//   history       bit 0 newest sample, bit HIST_DEPTH-1 oldest
//   alarm         sticky, high while the FSM sits in ALARM
//   state         IDLE=0, TRACK=1, ALARM=2
// ---------------------------------------------------------------------------
module cmp_result_monitor #(
  parameter int CNT_W      = 8,
  parameter int RUN_THRESH = 3,
  parameter int HIST_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  cmp_z,
  input  logic                  clear,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      sample_count,
  output logic [CNT_W-1:0]      run_len,
  output logic [HIST_DEPTH-1:0] history,
  output logic                  alarm,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_THRESH);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] hit_next;
  logic [CNT_W-1:0] sample_next;

  // Next-state and next-statistics logic. The FSM only moves on accepted
  // samples. An illegal encoding falls back to IDLE and the sample seen in
  // that cycle is ignored, so the counters stay untouched while recovering.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    run_next    = run_len;
    hit_next    = hit_count;
    sample_next = sample_count;

    if (cmp_z) begin
      run_next = (run_len == CNT_MAX) ? CNT_MAX : run_len + 1'b1;
    end else begin
      run_next = '0;
    end

    if (cmp_z && (hit_count != CNT_MAX)) begin
      hit_next = hit_count + 1'b1;
    end

    if (sample_count != CNT_MAX) begin
      sample_next = sample_count + 1'b1;
    end

    case (state_q)
      IDLE, TRACK: begin
        accept = in_valid;
        if (in_valid) begin
          state_d = (run_next >= THRESH) ? ALARM : TRACK;
        end
      end
      ALARM: begin
        accept = in_valid;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs. Reset beats clear, clear beats a sample, and both
  // reset and clear drop any sample presented in the same cycle. The alarm
  // flop is loaded from the next state so it rises together with the
  // out_valid pulse of the triggering sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q      <= IDLE;
      out_valid    <= 1'b0;
      hit_count    <= '0;
      sample_count <= '0;
      run_len      <= '0;
      history      <= '0;
      alarm        <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm     <= (state_d == ALARM);
      out_valid <= accept;
      if (accept) begin
        hit_count    <= hit_next;
        sample_count <= sample_next;
        run_len      <= run_next;
        history      <= {history[HIST_DEPTH-2:0], cmp_z};
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_cmp_result_monitor
// Drives two monitors from the same stimulus: one with 8-bit counters and
// one with 3-bit counters so saturation is reached quickly. A behavioural
// model of the statistics is updated per clock and every output of both
// instances is compared after each edge. Directed sequences come first,
// then a randomized run with occasional clears and resets.
// ---------------------------------------------------------------------------
module tb_cmp_result_monitor;

  logic clk;
  logic rst;
  logic in_valid;
  logic cmp_z;
  logic clear;

  logic       ov_a;
  logic [7:0] hit_a;
  logic [7:0] samp_a;
  logic [7:0] run_a;
  logic [7:0] hist_a;
  logic       alarm_a;
  logic [1:0] state_a;

  logic       ov_b;
  logic [2:0] hit_b;
  logic [2:0] samp_b;
  logic [2:0] run_b;
  logic [7:0] hist_b;
  logic       alarm_b;
  logic [1:0] state_b;

  int assertions;
  int failures;

  // behavioural model, index 0 = 8-bit instance, index 1 = 3-bit instance
  int m_max[2];
  int m_hit[2];
  int m_samp[2];
  int m_run[2];
  int m_hist[2];
  int m_ov[2];
  int m_alarmed[2];
  int m_started[2];

  cmp_result_monitor #(.CNT_W(8), .RUN_THRESH(3), .HIST_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmp_z(cmp_z), .clear(clear),
    .out_valid(ov_a), .hit_count(hit_a), .sample_count(samp_a),
    .run_len(run_a), .history(hist_a), .alarm(alarm_a), .state(state_a)
  );

  cmp_result_monitor #(.CNT_W(3), .RUN_THRESH(3), .HIST_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmp_z(cmp_z), .clear(clear),
    .out_valid(ov_b), .hit_count(hit_b), .sample_count(samp_b),
    .run_len(run_b), .history(hist_b), .alarm(alarm_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point for the whole bench
  task automatic checkOutput(input string tag, input int obs, input int exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // statistics rules applied to one accepted/dropped sample
  task automatic modelStep(input bit v, input bit z, input bit c, input bit r);
    for (int i = 0; i < 2; i++) begin
      if (r || c) begin
        m_hit[i] = 0; m_samp[i] = 0; m_run[i] = 0; m_hist[i] = 0;
        m_ov[i] = 0; m_alarmed[i] = 0; m_started[i] = 0;
      end else if (v) begin
        m_ov[i]   = 1;
        m_samp[i] = (m_samp[i] + 1 > m_max[i]) ? m_max[i] : m_samp[i] + 1;
        m_hit[i]  = (m_hit[i] + z > m_max[i]) ? m_max[i] : m_hit[i] + z;
        m_run[i]  = z ? ((m_run[i] + 1 > m_max[i]) ? m_max[i] : m_run[i] + 1) : 0;
        m_hist[i] = ((m_hist[i] * 2) + z) % 256;
        m_started[i] = 1;
        if (m_run[i] >= 3) m_alarmed[i] = 1;
      end else begin
        m_ov[i] = 0;
      end
    end
  endtask

  task automatic checkAll(input string pfx);
    int st[2];
    for (int i = 0; i < 2; i++) begin
      st[i] = m_alarmed[i] ? 2 : (m_started[i] ? 1 : 0);
    end
    checkOutput({pfx, " A out_valid"}, int'(ov_a), m_ov[0]);
    checkOutput({pfx, " A hit_count"}, int'(hit_a), m_hit[0]);
    checkOutput({pfx, " A sample_count"}, int'(samp_a), m_samp[0]);
    checkOutput({pfx, " A run_len"}, int'(run_a), m_run[0]);
    checkOutput({pfx, " A history"}, int'(hist_a), m_hist[0]);
    checkOutput({pfx, " A alarm"}, int'(alarm_a), m_alarmed[0]);
    checkOutput({pfx, " A state"}, int'(state_a), st[0]);
    checkOutput({pfx, " B out_valid"}, int'(ov_b), m_ov[1]);
    checkOutput({pfx, " B hit_count"}, int'(hit_b), m_hit[1]);
    checkOutput({pfx, " B sample_count"}, int'(samp_b), m_samp[1]);
    checkOutput({pfx, " B run_len"}, int'(run_b), m_run[1]);
    checkOutput({pfx, " B history"}, int'(hist_b), m_hist[1]);
    checkOutput({pfx, " B alarm"}, int'(alarm_b), m_alarmed[1]);
    checkOutput({pfx, " B state"}, int'(state_b), st[1]);
  endtask

  // one clock of stimulus, model update on the edge, check 1 time unit later
  task automatic applyStimulus(input string pfx, input bit v, input bit z,
                               input bit c, input bit r);
    in_valid = v;
    cmp_z    = z;
    clear    = c;
    rst      = r;
    @(posedge clk);
    modelStep(v, z, c, r);
    #1;
    checkAll(pfx);
  endtask

  initial begin
    bit zs[5];
    assertions = 0;
    failures   = 0;
    m_max[0] = 255;
    m_max[1] = 7;
    rst = 1'b1; in_valid = 1'b0; cmp_z = 1'b0; clear = 1'b0;

    // 1: reset held two cycles
    applyStimulus("rst0", 0, 0, 0, 1);
    applyStimulus("rst1", 0, 0, 0, 1);
    checkOutput("reset state const", int'(state_a), 0);

    // 2: z = 1,0,1,1,1 back to back
    zs = '{1, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) applyStimulus("seq", 1, zs[i], 0, 0);
    checkOutput("seq sample_count const", int'(samp_a), 5);
    checkOutput("seq hit_count const", int'(hit_a), 4);
    checkOutput("seq run_len const", int'(run_a), 3);
    checkOutput("seq history const", int'(hist_a[4:0]), 5'b10111);
    checkOutput("seq alarm const", int'(alarm_a), 1);

    // 3: alarm is sticky through misses, then cleared
    for (int i = 0; i < 4; i++) applyStimulus("sticky", 1, 0, 0, 0);
    checkOutput("sticky state const", int'(state_a), 2);
    checkOutput("sticky run_len const", int'(run_a), 0);
    applyStimulus("clear", 0, 0, 1, 0);
    applyStimulus("clear_drop", 1, 1, 1, 0);
    checkOutput("clear drop out_valid const", int'(ov_a), 0);
    applyStimulus("idle_hold", 0, 0, 0, 0);

    // 4: nine hits saturate the 3-bit instance at 7
    for (int i = 0; i < 9; i++) applyStimulus("sat", 1, 1, 0, 0);
    checkOutput("sat B hit const", int'(hit_b), 7);
    checkOutput("sat B samp const", int'(samp_b), 7);
    checkOutput("sat B run const", int'(run_b), 7);
    applyStimulus("clear2", 0, 0, 1, 0);

    // 5: gaps between hits keep the run going
    applyStimulus("gap", 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("gap_idle", 0, 1, 0, 0);
    applyStimulus("gap", 1, 1, 0, 0);
    applyStimulus("gap", 1, 1, 0, 0);
    checkOutput("gap run_len const", int'(run_a), 3);
    checkOutput("gap alarm const", int'(alarm_a), 1);
    applyStimulus("clear3", 0, 0, 1, 0);

    // 6: reset in the middle of a run
    applyStimulus("mid", 1, 1, 0, 0);
    applyStimulus("mid", 1, 1, 0, 0);
    checkOutput("mid state const", int'(state_a), 1);
    applyStimulus("mid_rst", 1, 1, 0, 1);
    applyStimulus("post_rst", 1, 1, 0, 0);
    checkOutput("post_rst run const", int'(run_a), 1);
    checkOutput("post_rst state const", int'(state_a), 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
